// File: rtl/branch_wb_arbiter_pkg.sv
// Shared backend types for the branch writeback arbiter: ROB/FTQ index
// types, the branch writeback payload and the wrap-aware ROB age compare.
package branch_wb_arbiter_pkg;

    localparam int ROB_IDX_W = 7;   // 128-entry ROB, plus one wrap flag bit
    localparam int FTQ_IDX_W = 6;
    localparam int TARGET_W  = 32;

    typedef struct packed {
        logic                 flag;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;

    typedef struct packed {
        robIdx_t             rob_idx;
        ftqIdx_t             ftq_idx;
        logic                has_mispred;
        logic                taken;
        logic [TARGET_W-1:0] target;
        logic [3:0]          ftq_offset;
    } branchwbInfo_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } mispred_state_e;

    // a is older than b. The flag toggles on every ROB wrap, so with
    // differing flags the larger raw index belongs to the earlier lap.
    // Equal robIdx is never older.
    function automatic logic rob_is_older(robIdx_t a, robIdx_t b);
        if (a.flag == b.flag) return a.idx < b.idx;
        else                  return a.idx > b.idx;
    endfunction

endpackage

// File: rtl/branch_wb_arbiter_if.sv
// Bus between the branch units / ROB and the arbiter. The master side
// drives lane writebacks, squash and ack; the slave side (the arbiter)
// drives the FTQ stream, the pending mispredict and the counter.
interface branch_wb_arbiter_if
    import branch_wb_arbiter_pkg::*;
#(
    parameter int BRU_NUM = 4,
    parameter int CNT_W   = 16
) ();

    logic          [BRU_NUM-1:0] i_branchwb_vld;
    branchwbInfo_t [BRU_NUM-1:0] i_branchwb_info;
    logic                        i_squash_vld;
    robIdx_t                     i_squash_robIdx;
    logic          [BRU_NUM-1:0] o_ftq_wb_vld;
    branchwbInfo_t [BRU_NUM-1:0] o_ftq_wb_info;
    logic                        o_mispred_vld;
    branchwbInfo_t               o_mispred_info;
    logic                        i_mispred_ack;
    logic          [CNT_W-1:0]   o_mispred_cnt;

    modport master (
        output i_branchwb_vld, i_branchwb_info, i_squash_vld, i_squash_robIdx,
               i_mispred_ack,
        input  o_ftq_wb_vld, o_ftq_wb_info, o_mispred_vld, o_mispred_info,
               o_mispred_cnt
    );

    modport slave (
        input  i_branchwb_vld, i_branchwb_info, i_squash_vld, i_squash_robIdx,
               i_mispred_ack,
        output o_ftq_wb_vld, o_ftq_wb_info, o_mispred_vld, o_mispred_info,
               o_mispred_cnt
    );

endinterface

// File: rtl/branch_wb_arbiter_age_oldest_tree.sv
// Log2 comparison tree that picks the oldest valid entry by ROB age.
// Each node prefers its left (lower-lane) child unless only the right one
// is valid or the right one is strictly older, so ties go to the lowest lane.
module age_oldest_tree
    import branch_wb_arbiter_pkg::*;
#(
    parameter int  WIDTH = 4,
    parameter type T     = logic,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic    [WIDTH-1:0] in_vld,
    input  robIdx_t [WIDTH-1:0] in_age,
    input  T        [WIDTH-1:0] in_data,
    output logic                out_vld,
    output logic    [IDX_W-1:0] out_idx,
    output T                    out_data
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int NP     = 1 << LEVELS;

    genvar l, i;
    for (l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = NP >> l;
        logic                      [N-1:0] vld;
        robIdx_t                   [N-1:0] age;
        T                          [N-1:0] data;
        logic [N-1:0][IDX_W-1:0]           lane;

        if (l == 0) begin : g_leaf
            // Leaves: real lanes, padded with invalid entries up to a power of two
            for (i = 0; i < N; i++) begin : g_in
                if (i < WIDTH) begin : g_real
                    assign vld[i]  = in_vld[i];
                    assign age[i]  = in_age[i];
                    assign data[i] = in_data[i];
                end else begin : g_pad
                    assign vld[i]  = 1'b0;
                    assign age[i]  = '0;
                    assign data[i] = '0;
                end
                assign lane[i] = IDX_W'(i);
            end
        end else begin : g_node
            // Inner nodes: merge child pair (2i, 2i+1) of the previous level
            for (i = 0; i < N; i++) begin : g_cmp
                logic take_r;
                assign take_r  = g_lvl[l-1].vld[2*i+1] &&
                                 (!g_lvl[l-1].vld[2*i] ||
                                  rob_is_older(g_lvl[l-1].age[2*i+1], g_lvl[l-1].age[2*i]));
                assign vld[i]  = g_lvl[l-1].vld[2*i] | g_lvl[l-1].vld[2*i+1];
                assign age[i]  = take_r ? g_lvl[l-1].age[2*i+1]  : g_lvl[l-1].age[2*i];
                assign data[i] = take_r ? g_lvl[l-1].data[2*i+1] : g_lvl[l-1].data[2*i];
                assign lane[i] = take_r ? g_lvl[l-1].lane[2*i+1] : g_lvl[l-1].lane[2*i];
            end
        end
    end

    assign out_vld  = g_lvl[LEVELS].vld[0];
    assign out_idx  = g_lvl[LEVELS].lane[0];
    assign out_data = g_lvl[LEVELS].data[0];

endmodule

// File: rtl/branch_wb_arbiter.sv
// Merges BRU_NUM branch writebacks into a registered, de-duplicated FTQ
// stream and a single held oldest-mispredict request for the ROB.
module branch_wb_arbiter
    import branch_wb_arbiter_pkg::*;
#(
    parameter int BRU_NUM = 4,
    parameter int CNT_W   = 16
) (
    input logic                clk,
    input logic                rst,
    branch_wb_arbiter_if.slave bus
);

    localparam int LANE_W = (BRU_NUM > 1) ? $clog2(BRU_NUM) : 1;

    logic    [BRU_NUM-1:0] lane_ok;
    logic    [BRU_NUM-1:0] lane_keep;
    logic    [BRU_NUM-1:0] lane_mis;
    robIdx_t [BRU_NUM-1:0] lane_age;

    logic                  cand_vld;
    logic     [LANE_W-1:0] cand_lane_unused;  // lane number is not needed downstream
    branchwbInfo_t         cand_info;
    logic                  held_squashed;

    mispred_state_e        state;
    branchwbInfo_t         held;
    logic      [CNT_W-1:0] cnt;
    logic    [BRU_NUM-1:0] ftq_vld_q;
    branchwbInfo_t [BRU_NUM-1:0] ftq_info_q;

    // Squash filter: drop lanes strictly younger than the squash point
    always_comb begin
        // NOTE: give every always_comb output a default before any branch so no path can infer a latch.
        lane_ok  = '0;
        lane_mis = '0;
        lane_age = '0;
        for (int k = 0; k < BRU_NUM; k++) begin
            lane_age[k] = bus.i_branchwb_info[k].rob_idx;
            lane_ok[k]  = bus.i_branchwb_vld[k] &&
                          !(bus.i_squash_vld &&
                            rob_is_older(bus.i_squash_robIdx, bus.i_branchwb_info[k].rob_idx));
            lane_mis[k] = lane_ok[k] && bus.i_branchwb_info[k].has_mispred;
        end
    end

    // Same-FTQ de-dup: a lane loses to any older lane on its ftq_idx, or to a lower lane of equal age
    always_comb begin
        lane_keep = lane_ok;
        for (int k = 0; k < BRU_NUM; k++) begin
            for (int j = 0; j < BRU_NUM; j++) begin
                if (j != k && lane_ok[j] &&
                    bus.i_branchwb_info[j].ftq_idx == bus.i_branchwb_info[k].ftq_idx &&
                    (rob_is_older(bus.i_branchwb_info[j].rob_idx, bus.i_branchwb_info[k].rob_idx) ||
                     (bus.i_branchwb_info[j].rob_idx == bus.i_branchwb_info[k].rob_idx && j < k))) begin
                    lane_keep[k] = 1'b0;
                end
            end
        end
    end

    age_oldest_tree #(
        .WIDTH (BRU_NUM),
        .T     (branchwbInfo_t)
    ) u_oldest (
        .in_vld   (lane_mis),
        .in_age   (lane_age),
        .in_data  (bus.i_branchwb_info),
        .out_vld  (cand_vld),
        .out_idx  (cand_lane_unused),
        .out_data (cand_info)
    );

    assign held_squashed = bus.i_squash_vld && rob_is_older(bus.i_squash_robIdx, held.rob_idx);

    // FTQ stream: one register stage, payload passes through untouched
    always_ff @(posedge clk) begin
        // NOTE: payload registers are reset too, so the info outputs read zero after reset rather than X.
        if (!rst) begin
            ftq_vld_q  <= '0;
            ftq_info_q <= '0;
        end else begin
            ftq_vld_q  <= lane_keep;
            ftq_info_q <= bus.i_branchwb_info;
        end
    end

    // Pending-mispredict FSM and saturating ack counter
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state <= IDLE;
            held  <= '0;
            cnt   <= '0;
        end else begin
            if (state == PEND && bus.i_mispred_ack && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cand_vld) begin
                        state <= PEND;
                        held  <= cand_info;
                    end
                end
                PEND: begin
                    if (bus.i_mispred_ack || held_squashed) begin
                        // Held entry is gone; a fresh candidate takes its place directly
                        if (cand_vld) held  <= cand_info;
                        else          state <= IDLE;
                    end else if (cand_vld && rob_is_older(cand_info.rob_idx, held.rob_idx)) begin
                        held <= cand_info;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ftq_wb_vld   = ftq_vld_q;
    assign bus.o_ftq_wb_info  = ftq_info_q;
    assign bus.o_mispred_vld  = (state == PEND);
    assign bus.o_mispred_info = held;
    assign bus.o_mispred_cnt  = cnt;

endmodule

// File: tb/tb_branch_wb_arbiter.sv
// Directed bench for branch_wb_arbiter. Expected outputs are queued when a
// step's stimulus is driven and popped/compared one cycle later.
module tb_branch_wb_arbiter;
    import branch_wb_arbiter_pkg::*;

    localparam int BRU_NUM = 4;
    localparam int CNT_W   = 3;   // narrow so saturation is reachable quickly

    typedef struct {
        string              tag;
        logic [BRU_NUM-1:0] ftq_vld;
        logic               mvld;
        robIdx_t            mrob;
        logic [CNT_W-1:0]   cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run = 0;
    int   failed    = 0;
    exp_t sb[$];

    branch_wb_arbiter_if #(.BRU_NUM(BRU_NUM), .CNT_W(CNT_W)) bus ();

    branch_wb_arbiter #(.BRU_NUM(BRU_NUM), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.i_branchwb_vld   = '0;
        bus.i_branchwb_info  = '0;
        bus.i_squash_vld     = 1'b0;
        bus.i_squash_robIdx  = '0;
        bus.i_mispred_ack    = 1'b0;
    endtask

    function automatic logic [TARGET_W-1:0] tgt(input int idx);
        return TARGET_W'(32'h8000_0000 + idx * 4);
    endfunction

    task automatic set_lane(input int ln, input logic flag, input int idx,
                            input int ftq, input logic mis);
        branchwbInfo_t w;
        w                 = '0;
        w.rob_idx.flag    = flag;
        w.rob_idx.idx     = ROB_IDX_W'(idx);
        w.ftq_idx         = FTQ_IDX_W'(ftq);
        w.has_mispred     = mis;
        w.taken           = 1'b1;
        w.target          = tgt(idx);
        bus.i_branchwb_vld[ln]  = 1'b1;
        bus.i_branchwb_info[ln] = w;
    endtask

    task automatic squash(input logic flag, input int idx);
        bus.i_squash_vld          = 1'b1;
        bus.i_squash_robIdx.flag  = flag;
        bus.i_squash_robIdx.idx   = ROB_IDX_W'(idx);
    endtask

    task automatic expect_out(input string tag, input logic [BRU_NUM-1:0] f,
                              input logic mv, input logic fl, input int idx, input int c);
        exp_t e;
        e.tag      = tag;
        e.ftq_vld  = f;
        e.mvld     = mv;
        e.mrob     = '{flag: fl, idx: ROB_IDX_W'(idx)};
        e.cnt      = CNT_W'(c);
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".ftq_vld"}, 64'(bus.o_ftq_wb_vld), 64'(e.ftq_vld));
        chk({e.tag, ".mis_vld"}, 64'(bus.o_mispred_vld), 64'(e.mvld));
        if (e.mvld) chk({e.tag, ".mis_rob"}, 64'(bus.o_mispred_info.rob_idx), 64'(e.mrob));
        chk({e.tag, ".cnt"}, 64'(bus.o_mispred_cnt), 64'(e.cnt));
    endtask

    initial begin
        // Reset with traffic present: the in-flight inputs must be discarded
        rst = 1'b0;
        clear_in();
        set_lane(0, 1'b0, 3, 1, 1'b1);
        bus.i_mispred_ack = 1'b1;
        expect_out("reset", 4'b0000, 1'b0, 1'b0, 0, 0);
        tick();
        chk("reset.mis_info", 64'(bus.o_mispred_info), 64'd0);
        for (int k = 0; k < BRU_NUM; k++) chk("reset.ftq_info", 64'(bus.o_ftq_wb_info[k]), 64'd0);
        rst = 1'b1;

        // Wrap-around: {0,120} is a lap earlier than {1,2}
        clear_in();
        set_lane(0, 1'b1, 2, 1, 1'b1);
        set_lane(1, 1'b0, 120, 2, 1'b1);
        expect_out("wrap", 4'b0011, 1'b1, 1'b0, 120, 0);
        tick();
        chk("wrap.target", 64'(bus.o_mispred_info.target), 64'(tgt(120)));
        chk("wrap.ftq_payload", 64'(bus.o_ftq_wb_info[0].rob_idx), 64'({1'b1, 7'd2}));

        clear_in();
        bus.i_mispred_ack = 1'b1;
        expect_out("ack1", 4'b0000, 1'b0, 1'b0, 0, 1);
        tick();

        // De-dup: ftq 5,5,7,5 with rob 10,8,9,8
        clear_in();
        set_lane(0, 1'b0, 10, 5, 1'b0);
        set_lane(1, 1'b0, 8, 5, 1'b0);
        set_lane(2, 1'b0, 9, 7, 1'b0);
        set_lane(3, 1'b0, 8, 5, 1'b0);
        expect_out("dedup", 4'b0110, 1'b0, 1'b0, 0, 1);
        tick();

        // Pending replace: 40 held, 30 replaces, 35 and equal-age 30 are dropped
        clear_in(); set_lane(0, 1'b0, 40, 1, 1'b1);
        expect_out("pend.load40", 4'b0001, 1'b1, 1'b0, 40, 1);
        tick();
        clear_in(); set_lane(0, 1'b0, 30, 1, 1'b1);
        expect_out("pend.repl30", 4'b0001, 1'b1, 1'b0, 30, 1);
        tick();
        clear_in(); set_lane(0, 1'b0, 35, 1, 1'b1);
        expect_out("pend.drop35", 4'b0001, 1'b1, 1'b0, 30, 1);
        tick();
        clear_in(); set_lane(2, 1'b0, 30, 3, 1'b1);
        expect_out("pend.drop_eq", 4'b0100, 1'b1, 1'b0, 30, 1);
        tick();
        clear_in(); bus.i_mispred_ack = 1'b1;
        expect_out("pend.ack", 4'b0000, 1'b0, 1'b0, 0, 2);
        tick();

        // Squash: held 50 cleared by squash at 45, lane at 45 survives and loads
        clear_in(); set_lane(0, 1'b0, 50, 1, 1'b1);
        expect_out("sq.load50", 4'b0001, 1'b1, 1'b0, 50, 2);
        tick();
        clear_in();
        squash(1'b0, 45);
        set_lane(0, 1'b0, 45, 1, 1'b1);
        set_lane(1, 1'b0, 47, 2, 1'b0);
        set_lane(2, 1'b0, 44, 3, 1'b0);
        expect_out("sq.replace45", 4'b0101, 1'b1, 1'b0, 45, 2);
        tick();
        clear_in(); squash(1'b0, 40);
        expect_out("sq.to_idle", 4'b0000, 1'b0, 1'b0, 0, 2);
        tick();

        // Ack while idle is ignored
        clear_in(); bus.i_mispred_ack = 1'b1;
        expect_out("idle_ack", 4'b0000, 1'b0, 1'b0, 0, 2);
        tick();

        // Ack plus new: 60 arrives in the ack cycle (younger than held 55)
        clear_in(); set_lane(0, 1'b0, 55, 1, 1'b1);
        expect_out("acknew.load55", 4'b0001, 1'b1, 1'b0, 55, 2);
        tick();
        clear_in(); set_lane(0, 1'b0, 60, 1, 1'b1); bus.i_mispred_ack = 1'b1;
        expect_out("acknew.60", 4'b0001, 1'b1, 1'b0, 60, 3);
        tick();

        // Counter saturation at 3'b111
        for (int k = 0; k < 5; k++) begin
            clear_in(); set_lane(0, 1'b0, 61 + k, 1, 1'b1); bus.i_mispred_ack = 1'b1;
            expect_out("sat", 4'b0001, 1'b1, 1'b0, 61 + k, (4 + k > 7) ? 7 : 4 + k);
            tick();
        end
        clear_in(); bus.i_mispred_ack = 1'b1;
        expect_out("sat.ack", 4'b0000, 1'b0, 1'b0, 0, 7);
        tick();

        // Wrap-aware squash from IDLE: {0,90} and {1,5} are younger than {0,80}; {0,80} survives
        clear_in();
        squash(1'b0, 80);
        set_lane(0, 1'b0, 90, 1, 1'b1);
        set_lane(1, 1'b1, 5, 2, 1'b1);
        set_lane(2, 1'b0, 80, 3, 1'b1);
        expect_out("sq.wrap", 4'b0100, 1'b1, 1'b0, 80, 7);
        tick();

        // Reset mid-PEND, then an ack with nothing pending
        rst = 1'b0;
        clear_in(); set_lane(0, 1'b0, 70, 1, 1'b1); bus.i_mispred_ack = 1'b1;
        expect_out("rst_mid", 4'b0000, 1'b0, 1'b0, 0, 0);
        tick();
        chk("rst_mid.mis_info", 64'(bus.o_mispred_info), 64'd0);
        rst = 1'b1;
        clear_in(); bus.i_mispred_ack = 1'b1;
        expect_out("rst_ack", 4'b0000, 1'b0, 1'b0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/branch_wb_arbiter.md
# branch_wb_arbiter

- Merges up to `BRU_NUM` branch-unit writebacks per cycle into two registered streams:
  - a de-duplicated, per-lane writeback stream to the FTQ;
  - a single oldest-mispredict request to the ROB, held until the ROB acknowledges it.
- Successor to the fixed two-BRU merge logic in the backend top. Adds:
  - generic lane count;
  - flag-aware ROB age comparison that is correct across wrap-around;
  - squash filtering;
  - a pending-mispredict holding register with handshake.
- Sits between `exeBlock` branch outputs and `ctrlBlock`/FTQ.

## Interface
Parameters:
- `BRU_NUM`, 4, number of branch writeback lanes (≥1).
- `CNT_W`, 16, width of the mispredict event counter.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low.
- `i_branchwb_vld` in `BRU_NUM`: per-lane writeback valid.
- `i_branchwb_info` in `branchwbInfo_t[BRU_NUM]`: carries `rob_idx` (flag+idx), `ftq_idx`, `has_mispred`, target, and the remaining fields.
- `i_squash_vld` in 1: ROB squash this cycle.
- `i_squash_robIdx` in `robIdx_t`: squash point.
- `o_ftq_wb_vld` out `BRU_NUM`: registered FTQ writeback valid.
- `o_ftq_wb_info` out `branchwbInfo_t[BRU_NUM]`: registered lane payload.
- `o_mispred_vld` out 1: pending oldest mispredict.
- `o_mispred_info` out `branchwbInfo_t`: payload of the pending mispredict.
- `i_mispred_ack` in 1: ROB consumed `o_mispred_info` this cycle.
- `o_mispred_cnt` out `CNT_W`: saturating count of accepted (acked) mispredicts.

## Operation
- **Age rule.** `older(a,b)`:
  - when flags are equal: `a.idx < b.idx`;
  - otherwise: `a.idx > b.idx`.
  - Equal robIdx is never older.
- **Squash filter.** With `i_squash_vld`, any lane whose `rob_idx` is strictly younger than `i_squash_robIdx` is invalid for both streams. The lane at exactly the squash point survives.
- **FTQ de-dup.**
  - Among filtered valid lanes sharing one `ftq_idx`, only the oldest keeps valid; the others are cleared.
  - Ties on robIdx: the lowest lane index wins.
  - Lanes keep their position; payload is passed unchanged.
- **Mispredict candidate.** Oldest filtered valid lane with `has_mispred`, selected by the `age_oldest_tree` sub-module; ties go to the lowest lane.
- **FSM states.** IDLE, PEND.
  - IDLE, candidate exists → PEND; load the candidate.
  - PEND, `i_mispred_ack`:
    - if a candidate exists this cycle, stay in PEND and load it;
    - otherwise → IDLE.
  - PEND, no ack:
    - replace the held entry if the candidate is older;
    - drop the candidate otherwise, including the equal-age case.
  - PEND, `i_squash_vld` with held entry strictly younger than the squash point → IDLE. A candidate may still load in the same cycle.
- **Counter.** Increments on `o_mispred_vld && i_mispred_ack` and saturates at all-ones.

## Timing
- FTQ stream: 1-cycle latency, input to `o_ftq_wb_*`. Registered outputs are never retracted by a later squash.
- Mispredict: visible the cycle after the candidate input. It stays stable until ack, replacement by an older entry, or squash.
- Ack is sampled only while `o_mispred_vld` is high; ack while IDLE is ignored.
- Reset (`rst` == 0 at a clock edge):
  - `o_ftq_wb_vld` = 0, `o_mispred_vld` = 0, `o_mispred_cnt` = 0, `o_*_info` = 0, FSM = IDLE;
  - any in-flight input in that cycle is discarded.
- No combinational path from any input to any output.

## Structure
- Shared backend package/`backend_define.svh` holds:
  - `robIdx_t`, `ftqIdx_t`, `branchwbInfo_t`;
  - function `rob_is_older(robIdx_t a, robIdx_t b)`, reused by the squash filter, de-dup and FSM.
- Sub-module `age_oldest_tree`:
  - parametrised by `WIDTH` and payload type;
  - log2 comparison tree;
  - outputs valid, lane index and data.
- Top holds the filter, the O(N²) same-ftq de-dup, the output registers, the FSM and the counter.

## Test plan
- **Wrap-around.** Lane0 `{flag=1, idx=2}` mispred and lane1 `{flag=0, idx=120}` mispred; ROB size 128 (7-bit idx, plus flag bit). → next cycle `o_mispred_info.rob_idx` = lane1.
- **De-dup.** Lanes 0..3 valid with `ftq_idx` 5, 5, 7, 5 and robIdx 10, 8, 9, 8. → `o_ftq_wb_vld` = 4'b0110 (lane1 is oldest among 8/8 by lowest-lane tie; lane2 unique).
- **Pending replace.** Held mispred robIdx 40, no ack. Inputs:
  - candidate robIdx 30 → replaces the held entry;
  - next cycle candidate 35 → dropped.
  - After ack → IDLE, `o_mispred_cnt` = 1.
- **Squash.** Held entry robIdx 50. `i_squash_vld` with squash robIdx 45 and a lane mispred at 45 in the same cycle. → held entry cleared, 45 loaded, `o_mispred_vld` stays 1.
- **Ack plus new.** Ack in the same cycle as a new mispred at 60. → `o_mispred_vld` stays 1 with 60; counter +1.
- **Reset mid-PEND.** Drive `rst` = 0 for one cycle. → all outputs 0; a later ack with no pending entry leaves the counter at 0.
